// File: rtl/game_pkg.sv
// game_pkg: game-state encodings, play-area and sprite sizes, hit-detector FSM states.
package game_pkg;
  localparam logic [1:0] IDLE_S = 2'b00;
  localparam logic [1:0] PLAY   = 2'b01;
  localparam logic [1:0] END_S  = 2'b10;
  localparam int PLAY_W = 960;
  localparam int PLAY_H = 704;
  localparam int DUCK_SIZE_W = 64;
  localparam int DUCK_SIZE_H = 64;
  typedef enum logic [1:0] {HD_IDLE, HD_ARMED, HD_CHECK, HD_COOL} hit_fsm_e;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/click_edge_det.sv
// click_edge_det: one-cycle pulse on the rising edge of a button level.
module click_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);
  logic level_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/duck_hit_detector.sv
// duck_hit_detector: judges left clicks against the duck hit box, pulses on hits, keeps scores.
module duck_hit_detector
  import game_pkg::*;
#(
  parameter int DUCK_W   = DUCK_SIZE_W,
  parameter int DUCK_H   = DUCK_SIZE_H,
  parameter int COOLDOWN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [9:0]  duck_x,
  input  logic [9:0]  duck_y,
  output logic        clicked_duck,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count
);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  hit_fsm_e fsm_q, fsm_d;
  logic [11:0] cx_q, cx_d, cy_q, cy_d, dx_q, dx_d, dy_q, dy_d;
  logic [7:0] hits_q, hits_d, miss_q, miss_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d, click, hit;
  click_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst),
    .level_i (mouse_left),
    .rise_o  (click)
  );
  // Right/bottom edges exclusive; 12-bit sums cannot overflow for 10-bit duck coordinates.
  assign hit = (cx_q >= dx_q) && (cx_q < dx_q + 12'(DUCK_W)) &&
               (cy_q >= dy_q) && (cy_q < dy_q + 12'(DUCK_H));
  always_comb begin
    fsm_d   = fsm_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (state != PLAY) fsm_d = HD_IDLE;
    else
      case (fsm_q)
        HD_IDLE: begin
          hits_d = '0;
          miss_d = '0;
          fsm_d  = HD_ARMED;
        end
        HD_ARMED: if (click) begin
          cx_d  = mouse_xpos;
          cy_d  = mouse_ypos;
          dx_d  = {2'b00, duck_x};
          dy_d  = {2'b00, duck_y};
          fsm_d = HD_CHECK;
        end
        HD_CHECK: begin
          pulse_d = hit;
          hits_d  = hit ? sat_inc(hits_q) : hits_q;
          miss_d  = hit ? miss_q : sat_inc(miss_q);
          cnt_d   = CW'(COOLDOWN - 1);
          fsm_d   = HD_COOL;
        end
        HD_COOL: begin
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
          fsm_d = (cnt_q == '0 && !mouse_left) ? HD_ARMED : HD_COOL;
        end
        default: fsm_d = HD_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= HD_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      hits_q  <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign clicked_duck = pulse_q;
  assign hit_count    = hits_q;
  assign miss_count   = miss_q;
endmodule

// File: tb/tb_duck_hit_detector.sv
// tb_duck_hit_detector: directed and randomized shots checked against a hit-box/score model.
module tb_duck_hit_detector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  state = 2'b00;
  logic        mouse_left = 1'b0;
  logic [11:0] mx = '0, my = '0;
  logic [9:0]  dx = '0, dy = '0;
  logic        clicked;
  logic [7:0]  hc, mc;
  int n_chk = 0, n_err = 0;
  int exp_h = 0, exp_m = 0;
  int pulses;

  always #5 clk = ~clk;

  duck_hit_detector dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .mouse_left   (mouse_left),
    .mouse_xpos   (mx),
    .mouse_ypos   (my),
    .duck_x       (dx),
    .duck_y       (dy),
    .clicked_duck (clicked),
    .hit_count    (hc),
    .miss_count   (mc)
  );

  function automatic int ref_hit(input int cx, input int cy, input int x, input int y);
    return (cx >= x && cx < x + 64 && cy >= y && cy < y + 64) ? 1 : 0;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot(input int x, input int y, input string tag);
    int h;
    h = ref_hit(x, y, int'(dx), int'(dy));
    mx = 12'(x);
    my = 12'(y);
    mouse_left = 1'b1;
    tick();
    check({tag, "_pre"}, clicked, 0);
    mouse_left = 1'b0;
    tick();
    check({tag, "_pulse"}, clicked, h);
    if (h != 0) exp_h = sat(exp_h + 1); else exp_m = sat(exp_m + 1);
    tick();
    check({tag, "_drop"}, clicked, 0);
    check({tag, "_hits"}, hc, exp_h);
    check({tag, "_miss"}, mc, exp_m);
    repeat (18) tick();
  endtask

  task automatic reenter();
    state = 2'b10;
    tick();
    state = 2'b01;
    tick();
    exp_h = 0;
    exp_m = 0;
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    repeat (2) tick();
    check("rst_clicked", clicked, 0);
    check("rst_hits", hc, 0);
    check("rst_miss", mc, 0);
    rst = 1'b1;
    state = 2'b01;
    tick();
    dx = 10'd100;
    dy = 10'd200;
    shoot(130, 230, "basic");

    reenter();
    check("reenter_hits", hc, 0);
    shoot(100, 200, "b_topleft");
    shoot(163, 263, "b_botright");
    shoot(164, 230, "b_right");
    shoot(130, 264, "b_bottom");
    check("bound_hits", hc, 2);
    check("bound_miss", mc, 2);

    mx = 12'd130;
    my = 12'd230;
    mouse_left = 1'b1;
    pulses = 0;
    repeat (100) begin
      tick();
      if (clicked) pulses++;
    end
    mouse_left = 1'b0;
    exp_h = sat(exp_h + 1);
    check("held_pulses", pulses, 1);
    check("held_hits", hc, exp_h);
    repeat (20) tick();

    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      mouse_left = (i == 0 || i == 6);
      tick();
      if (clicked) pulses++;
    end
    exp_h = sat(exp_h + 1);
    check("cd_pulses", pulses, 1);
    check("cd_hits", hc, exp_h);
    check("cd_miss", mc, exp_m);
    shoot(130, 230, "post_cd");

    mx = 12'd130;
    my = 12'd230;
    mouse_left = 1'b1;
    tick();
    dx = 10'd500;
    dy = 10'd400;
    mouse_left = 1'b0;
    tick();
    check("respawn_pulse", clicked, ref_hit(130, 230, 100, 200));
    exp_h = sat(exp_h + 1);
    tick();
    check("respawn_hits", hc, exp_h);
    repeat (18) tick();

    for (int i = 0; i < 40; i++) begin
      dx = 10'($urandom_range(0, 1023));
      dy = 10'($urandom_range(0, 1023));
      shoot(clamp(int'(dx) + int'($urandom_range(0, 80)) - 8),
            clamp(int'(dy) + int'($urandom_range(0, 80)) - 8), "rand");
    end

    for (int i = 0; i < 260; i++) begin
      dx = 10'($urandom_range(0, 896));
      dy = 10'($urandom_range(0, 640));
      shoot(int'(dx) + int'($urandom_range(0, 63)), int'(dy) + int'($urandom_range(0, 63)), "sat");
    end
    check("sat_hits", hc, 255);

    state = 2'b10;
    repeat (3) tick();
    check("end_hits", hc, 255);
    check("end_miss", mc, exp_m);
    state = 2'b01;
    tick();
    exp_h = 0;
    exp_m = 0;
    check("replay_hits", hc, 0);
    check("replay_miss", mc, 0);

    dx = 10'd100;
    dy = 10'd200;
    shoot(130, 230, "pre_leave");
    mx = 12'd130;
    my = 12'd230;
    mouse_left = 1'b1;
    tick();
    state = 2'b10;
    mouse_left = 1'b0;
    tick();
    check("leave_pulse", clicked, 0);
    tick();
    check("leave_hits", hc, exp_h);
    check("leave_miss", mc, exp_m);
    state = 2'b01;
    tick();
    exp_h = 0;
    exp_m = 0;

    shoot(130, 230, "pre_rst");
    mouse_left = 1'b1;
    tick();
    rst = 1'b0;
    mouse_left = 1'b0;
    #1;
    check("rstmid_clicked", clicked, 0);
    check("rstmid_hits", hc, 0);
    check("rstmid_miss", mc, 0);
    pulses = 0;
    repeat (5) begin
      tick();
      if (clicked) pulses++;
    end
    check("rstmid_pulses", pulses, 0);
    rst = 1'b1;
    mouse_left = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      if (clicked) pulses++;
    end
    check("rel_held_pulses", pulses, 0);
    mouse_left = 1'b0;
    tick();
    exp_h = 0;
    exp_m = 0;
    shoot(130, 230, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/duck_hit_detector.md
Name: duck_hit_detector

Overview:
- Consumes the target coordinates produced by the duck position generator and the mouse click stream.
- Decides whether a left click landed on the duck.
- Emits a one-cycle clicked_duck pulse. That pulse feeds back into the generator and the game timer, causing respawn and a timer restart.
- Keeps hit and miss counters for the score overlay. Sits between the mouse controller and the game-logic/generator block, in the 960x704 play area.

Parameters:
- DUCK_W, 64, duck sprite width in pixels (hit box width)
- DUCK_H, 64, duck sprite height in pixels (hit box height)
- COOLDOWN, 16, clock cycles during which further clicks are ignored after any shot

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- state  in  2  game state; PLAY encoding from the shared package
- mouse_left  in  1  left button level from the mouse controller
- mouse_xpos  in  12  cursor x in pixels
- mouse_ypos  in  12  cursor y in pixels
- duck_x  in  10  duck top-left x (hor_data from the generator)
- duck_y  in  10  duck top-left y (ver_data from the generator)
- clicked_duck  out  1  one-cycle hit pulse, registered
- hit_count  out  8  hits since entering PLAY, saturating
- miss_count  out  8  misses since entering PLAY, saturating

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE; clicked_duck=0, hit_count=0, miss_count=0; internal mouse_left delay register=0; cooldown counter=0.
- Click edge: mouse_left_d is a 1-cycle delayed copy of mouse_left. A click is the cycle where mouse_left=1 and mouse_left_d=0. A held button produces exactly one click.
- FSM states: IDLE, ARMED, CHECK, COOLDOWN.
- IDLE: when state==PLAY, clear hit_count and miss_count, then go to ARMED.
- ARMED: on a click, latch mouse_xpos, mouse_ypos, duck_x and duck_y into capture registers, then go to CHECK.
- CHECK (exactly one cycle): compute hit using the captured values, zero-extended to 12 bits.
  - hit condition: cx >= dx && cx < dx+DUCK_W && cy >= dy && cy < dy+DUCK_H.
  - Left and top edges are inclusive; right and bottom edges are exclusive.
  - Sums use 12-bit arithmetic, so there is no overflow for dx ≤ 1023.
  - On hit: clicked_duck <= 1 and hit_count increments.
  - On miss: miss_count increments.
  - Load the cooldown counter with COOLDOWN-1 and go to COOLDOWN.
- Latency: clicked_duck is high in the cycle after CHECK, i.e. two clocks after the cycle in which the click edge was sampled. It is high for exactly one cycle.
- COOLDOWN: counter decrements each cycle. Leave for ARMED only when the counter is 0 and mouse_left==0. Clicks here are ignored and not counted.
- Counters saturate at 255; they do not wrap.
- Leaving PLAY: if state!=PLAY in any state, go to IDLE next cycle.
  - A CHECK cycle that coincides with state!=PLAY produces no pulse and no counter update.
  - Counters keep their values in IDLE so the end-of-game screen can read them. They are cleared only on re-entry to PLAY.
- Duck respawn during CHECK: duck_x and duck_y may change in the same cycle (timer expiry). The check uses the captured coordinates only.
- Reset mid-operation: everything returns to reset values immediately. No pulse is emitted after reset release until a new click edge is seen in ARMED.
- clicked_duck is 0 in every state except the cycle after a successful CHECK.

Decomposition:
- Shared package game_pkg:
  - game state encodings (IDLE_S=2'b00, PLAY=2'b01, END_S=2'b10)
  - play-area constants (960, 704)
  - duck sprite size constants (64x64), used as the DUCK_W and DUCK_H defaults
  - FSM state encoding for this block
- Natural sub-module: click_edge_det, holding the mouse_left synchronizer/delay and the rising-edge pulse. It is reusable for the menu start click.
- The hit compare stays inline.

Test Plan:
- Reset, state=PLAY, duck=(100,200), click at (130,230) → clicked_duck high exactly 1 cycle, 2 clocks after the edge; hit_count=1, miss_count=0.
- Boundary: duck=(100,200); clicks at (100,200), (163,263), (164,230), (130,264), each separated by the cooldown → hit, hit, miss, miss; hit_count=2, miss_count=2.
- Button held high for 100 cycles over the duck → exactly one pulse. Second press at cycle 5 of cooldown → ignored. Press after cooldown and release → counted.
- Duck coordinates change to (500,400) in the CHECK cycle of a click at (130,230) on duck (100,200) → still a hit.
- 260 hits → hit_count saturates at 255. Then state leaves PLAY → counts held; re-enter PLAY → counts cleared to 0.
- Assert rst low during CHECK → clicked_duck never pulses, counters 0, FSM in IDLE. Release rst with state=PLAY → ARMED next cycle.
